// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: APB register word indices, STATUS
// bit positions, frame geometry, default device ID and the frame FSM states.
package spi_slave_pkg;

    // APB register word indices, decoded from paddr[3:2]
    localparam logic [1:0] REG_STATUS  = 2'd0;   // byte offset 0x0
    localparam logic [1:0] REG_RX_DATA = 2'd1;   // byte offset 0x4
    localparam logic [1:0] REG_TX_DATA = 2'd2;   // byte offset 0x8
    localparam logic [1:0] REG_CTRL    = 2'd3;   // byte offset 0xC

    // STATUS bit positions
    localparam int ST_BUSY      = 0;
    localparam int ST_RX_VALID  = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_LAST_RD   = 3;
    localparam int ST_ADDR_LSB  = 8;
    localparam int ST_ADDR_MSB  = 15;

    // Frame geometry: command byte, address byte, 32-bit data word
    localparam logic [5:0] FRAME_BITS = 6'd48;
    localparam logic [5:0] CMD_LAST   = 6'd7;
    localparam logic [5:0] ADDR_LAST  = 6'd15;
    localparam logic [5:0] DATA_LAST  = FRAME_BITS - 6'd1;

    localparam logic [6:0] DEFAULT_DEV_ID = 7'h65;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_CMD,
        FR_ADDR,
        FR_WDATA,
        FR_RDATA,
        FR_IGNORE,
        FR_DONE
    } frame_state_e;

    // Command ID comparison against the configured device ID
    function automatic logic id_match(input logic [6:0] cmd_id, input logic [6:0] dev_id);
        return (cmd_id == dev_id);
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizers for csb, sclk and sdi plus edge detection of the
// synchronized sclk and csb in the sys_clk domain. The csb chain resets to
// its idle (deasserted) level so reset release never fabricates a select edge.
module spi_slave_sync (
    input  logic sys_clk,
    input  logic rst_b,
    input  logic csb,
    input  logic sclk,
    input  logic sdi,
    output logic csb_s,
    output logic sdi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic csb_rise,
    output logic csb_fall
);

    logic csb_meta_r;
    logic csb_sync_r;
    logic csb_dly_r;
    logic sclk_meta_r;
    logic sclk_sync_r;
    logic sclk_dly_r;
    logic sdi_meta_r;
    logic sdi_sync_r;

    // Synchronizer chains plus one delay stage for edge detection
    always_ff @(posedge sys_clk) begin
        if (!rst_b) begin
            csb_meta_r  <= 1'b1;
            csb_sync_r  <= 1'b1;
            csb_dly_r   <= 1'b1;
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_dly_r  <= 1'b0;
            sdi_meta_r  <= 1'b0;
            sdi_sync_r  <= 1'b0;
        end else begin
            csb_meta_r  <= csb;
            csb_sync_r  <= csb_meta_r;
            csb_dly_r   <= csb_sync_r;
            sclk_meta_r <= sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_dly_r  <= sclk_sync_r;
            sdi_meta_r  <= sdi;
            sdi_sync_r  <= sdi_meta_r;
        end
    end

    assign csb_s     = csb_sync_r;
    assign sdi_s     = sdi_sync_r;
    assign sclk_rise =  sclk_sync_r & ~sclk_dly_r;
    assign sclk_fall = ~sclk_sync_r &  sclk_dly_r;
    assign csb_rise  =  csb_sync_r  & ~csb_dly_r;
    assign csb_fall  = ~csb_sync_r  &  csb_dly_r;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with an APB register interface. A 48-bit frame carries a
// command byte (bit7 read, bits[6:0] ID), an address byte and a 32-bit word.
// Optional macro SPI_SLAVE_ID_CHECK_EN: when defined, frames whose command
// ID differs from DEV_ID are ignored; otherwise any ID is accepted.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ID = DEFAULT_DEV_ID
) (
    input  logic        sys_clk,
    input  logic        rst_b,
    input  logic [31:0] apb_spi_paddr,
    input  logic        apb_spi_psel,
    input  logic        apb_spi_penable,
    input  logic        apb_spi_pwrite,
    input  logic [31:0] apb_spi_pwdata,
    output logic [31:0] spi_apb_prdata,
    input  logic        csb,
    input  logic        sclk,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_en
);

    // Synchronized SPI inputs and edge strobes
    logic csb_s;
    logic sdi_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic csb_rise_s;
    logic csb_fall_s;

    // Registers
    logic        ctrl_spi_dis_r;
    logic [23:0] ctrl_scratch_r;
    logic [31:0] tx_data_r;
    logic [31:0] rx_data_r;
    logic        rx_valid_r;
    logic        frame_err_r;
    logic        last_rd_r;
    logic [7:0]  last_addr_r;

    // Frame engine state
    frame_state_e frame_state_r;
    frame_state_e frame_next_s;
    logic [5:0]   bit_cnt_r;
    logic [30:0]  rx_shift_r;
    logic         cmd_rd_r;
    logic [7:0]   addr_r;
    logic [31:0]  tx_shift_r;
    logic         sdo_r;
    logic         sdo_en_r;

    // Decoded strobes
    logic [1:0]  reg_idx_s;
    logic        apb_wr_s;
    logic        apb_rd_s;
    logic        spi_rise_s;
    logic        spi_fall_s;
    logic [7:0]  cmd_byte_s;
    logic [7:0]  addr_byte_s;
    logic [31:0] data_word_s;
    logic        cmd_accept_s;
    logic        wr_done_s;
    logic        rd_load_s;
    logic        frame_err_set_s;
    logic [31:0] status_s;
    logic [31:0] prdata_s;
    logic        paddr_unused_s;

    spi_slave_sync u_sync (
        .sys_clk   (sys_clk),
        .rst_b     (rst_b),
        .csb       (csb),
        .sclk      (sclk),
        .sdi       (sdi),
        .csb_s     (csb_s),
        .sdi_s     (sdi_s),
        .sclk_rise (sclk_rise_s),
        .sclk_fall (sclk_fall_s),
        .csb_rise  (csb_rise_s),
        .csb_fall  (csb_fall_s)
    );

    assign reg_idx_s      = apb_spi_paddr[3:2];
    assign apb_wr_s       = apb_spi_psel & apb_spi_penable &  apb_spi_pwrite;
    assign apb_rd_s       = apb_spi_psel & apb_spi_penable & ~apb_spi_pwrite;
    assign paddr_unused_s = ^{apb_spi_paddr[31:4], apb_spi_paddr[1:0]};

    // sclk edges only count while selected and outside a select transition
    assign spi_rise_s  = sclk_rise_s & ~csb_s & ~csb_fall_s;
    assign spi_fall_s  = sclk_fall_s & ~csb_s & ~csb_fall_s;

    assign cmd_byte_s  = {rx_shift_r[6:0], sdi_s};
    assign addr_byte_s = {rx_shift_r[6:0], sdi_s};
    assign data_word_s = {rx_shift_r[30:0], sdi_s};

`ifdef SPI_SLAVE_ID_CHECK_EN
    assign cmd_accept_s = ~ctrl_spi_dis_r & id_match(cmd_byte_s[6:0], DEV_ID);
`else
    logic id_check_unused_s;
    assign id_check_unused_s = ^DEV_ID;
    assign cmd_accept_s      = ~ctrl_spi_dis_r;
`endif

    assign wr_done_s = spi_rise_s & (frame_state_r == FR_WDATA) & (bit_cnt_r == DATA_LAST);
    assign rd_load_s = spi_rise_s & (frame_state_r == FR_ADDR) & (bit_cnt_r == ADDR_LAST) & cmd_rd_r;

    // Only an accepted frame that stops mid-way is an error; ignored frames stay silent
    assign frame_err_set_s = csb_rise_s & (bit_cnt_r != 6'd0) & (bit_cnt_r != FRAME_BITS) &
                             ((frame_state_r == FR_CMD)   || (frame_state_r == FR_ADDR) ||
                              (frame_state_r == FR_WDATA) || (frame_state_r == FR_RDATA));

    // Frame state register
    always_ff @(posedge sys_clk) begin
        if (!rst_b) begin
            frame_state_r <= FR_IDLE;
        end else begin
            frame_state_r <= frame_next_s;
        end
    end

    // Frame next-state: select edges dominate, sclk rises advance field by field
    always_comb begin
        frame_next_s = frame_state_r;
        if (csb_rise_s) begin
            frame_next_s = FR_IDLE;
        end else if (csb_fall_s) begin
            frame_next_s = FR_CMD;
        end else if (spi_rise_s) begin
            case (frame_state_r)
                FR_CMD: begin
                    if (bit_cnt_r == CMD_LAST) begin
                        frame_next_s = cmd_accept_s ? FR_ADDR : FR_IGNORE;
                    end else begin
                        frame_next_s = FR_CMD;
                    end
                end
                FR_ADDR: begin
                    if (bit_cnt_r == ADDR_LAST) begin
                        frame_next_s = cmd_rd_r ? FR_RDATA : FR_WDATA;
                    end else begin
                        frame_next_s = FR_ADDR;
                    end
                end
                FR_WDATA, FR_RDATA: begin
                    if (bit_cnt_r == DATA_LAST) begin
                        frame_next_s = FR_DONE;
                    end else begin
                        frame_next_s = frame_state_r;
                    end
                end
                default: frame_next_s = frame_state_r;
            endcase
        end else begin
            frame_next_s = frame_state_r;
        end
    end

    // Bit counter and receive shift register; extra bits past the frame are dropped
    always_ff @(posedge sys_clk) begin
        if (!rst_b) begin
            bit_cnt_r  <= 6'd0;
            rx_shift_r <= 31'd0;
        end else if (csb_fall_s || csb_rise_s) begin
            bit_cnt_r  <= 6'd0;
            rx_shift_r <= 31'd0;
        end else if (spi_rise_s && (bit_cnt_r != FRAME_BITS)) begin
            bit_cnt_r  <= bit_cnt_r + 6'd1;
            rx_shift_r <= {rx_shift_r[29:0], sdi_s};
        end
    end

    // Latch command direction and address as their bytes complete
    always_ff @(posedge sys_clk) begin
        if (!rst_b) begin
            cmd_rd_r <= 1'b0;
            addr_r   <= 8'd0;
        end else if (csb_fall_s) begin
            cmd_rd_r <= 1'b0;
            addr_r   <= 8'd0;
        end else if (spi_rise_s && (frame_state_r == FR_CMD) && (bit_cnt_r == CMD_LAST)) begin
            cmd_rd_r <= cmd_byte_s[7];
        end else if (spi_rise_s && (frame_state_r == FR_ADDR) && (bit_cnt_r == ADDR_LAST)) begin
            addr_r <= addr_byte_s;
        end
    end

    // Transmit path: load the snapshot of TX_DATA, then shift MSB first on sclk falls
    always_ff @(posedge sys_clk) begin
        if (!rst_b) begin
            tx_shift_r <= 32'd0;
            sdo_r      <= 1'b0;
            sdo_en_r   <= 1'b0;
        end else if (csb_rise_s || csb_fall_s) begin
            tx_shift_r <= 32'd0;
            sdo_r      <= 1'b0;
            sdo_en_r   <= 1'b0;
        end else if (rd_load_s) begin
            tx_shift_r <= tx_data_r;
        end else if (spi_fall_s && (frame_state_r == FR_RDATA)) begin
            sdo_r      <= tx_shift_r[31];
            sdo_en_r   <= 1'b1;
            tx_shift_r <= {tx_shift_r[30:0], 1'b0};
        end
    end

    assign sdo    = sdo_r & sdo_en_r;
    assign sdo_en = sdo_en_r;

    // Software-writable registers: TX_DATA and CTRL
    always_ff @(posedge sys_clk) begin
        if (!rst_b) begin
            tx_data_r      <= 32'd0;
            ctrl_spi_dis_r <= 1'b0;
            ctrl_scratch_r <= 24'd0;
        end else if (apb_wr_s) begin
            case (reg_idx_s)
                REG_TX_DATA: tx_data_r <= apb_spi_pwdata;
                REG_CTRL: begin
                    ctrl_spi_dis_r <= apb_spi_pwdata[0];
                    ctrl_scratch_r <= apb_spi_pwdata[31:8];
                end
                default: ;
            endcase
        end
    end

    // Frame results: received word, last address and direction
    always_ff @(posedge sys_clk) begin
        if (!rst_b) begin
            rx_data_r   <= 32'd0;
            last_addr_r <= 8'd0;
            last_rd_r   <= 1'b0;
        end else if (wr_done_s) begin
            rx_data_r   <= data_word_s;
            last_addr_r <= addr_r;
            last_rd_r   <= 1'b0;
        end else if (rd_load_s) begin
            last_addr_r <= addr_byte_s;
            last_rd_r   <= 1'b1;
        end
    end

    // Sticky flags: a hardware set in the same cycle as a read-clear wins
    always_ff @(posedge sys_clk) begin
        if (!rst_b) begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (wr_done_s) begin
                rx_valid_r <= 1'b1;
            end else if (apb_rd_s && (reg_idx_s == REG_RX_DATA)) begin
                rx_valid_r <= 1'b0;
            end
            if (frame_err_set_s) begin
                frame_err_r <= 1'b1;
            end else if (apb_rd_s && (reg_idx_s == REG_STATUS)) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    // STATUS word assembly
    always_comb begin
        status_s                          = 32'd0;
        status_s[ST_BUSY]                 = ~csb_s;
        status_s[ST_RX_VALID]             = rx_valid_r;
        status_s[ST_FRAME_ERR]            = frame_err_r;
        status_s[ST_LAST_RD]              = last_rd_r;
        status_s[ST_ADDR_MSB:ST_ADDR_LSB] = last_addr_r;
    end

    // APB read mux, driven only during a selected read
    always_comb begin
        prdata_s = 32'd0;
        if (apb_spi_psel && !apb_spi_pwrite) begin
            case (reg_idx_s)
                REG_STATUS:  prdata_s = status_s;
                REG_RX_DATA: prdata_s = rx_data_r;
                REG_TX_DATA: prdata_s = tx_data_r;
                REG_CTRL:    prdata_s = {ctrl_scratch_r, 7'd0, ctrl_spi_dis_r};
                default:     prdata_s = 32'd0;
            endcase
        end else begin
            prdata_s = 32'd0;
        end
    end

    assign spi_apb_prdata = prdata_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: APB register access, SPI write/read frames,
// ignored frames, truncated frames and reset mid-frame, checked via a scoreboard.
module tb_spi_slave;

    logic        sys_clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        csb = 1'b1;
    logic        sclk = 1'b0;
    logic        sdi = 1'b0;
    logic        sdo;
    logic        sdo_en;

    int n_asserts = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  sdo_q[$];

    spi_slave #(.DEV_ID(7'h65)) dut (
        .sys_clk         (sys_clk),
        .rst_b           (rst_b),
        .apb_spi_paddr   (paddr),
        .apb_spi_psel    (psel),
        .apb_spi_penable (penable),
        .apb_spi_pwrite  (pwrite),
        .apb_spi_pwdata  (pwdata),
        .spi_apb_prdata  (prdata),
        .csb             (csb),
        .sclk            (sclk),
        .sdi             (sdi),
        .sdo             (sdo),
        .sdo_en          (sdo_en)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge sys_clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(negedge sys_clk);
        penable = 1'b1;
        @(negedge sys_clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read_check(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] obs;
        logic [31:0] want;
        exp_q.push_back(exp);
        @(negedge sys_clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        @(negedge sys_clk);
        penable = 1'b1;
        obs = prdata;
        want = exp_q.pop_front();
        check(tag, obs, want);
        @(negedge sys_clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    // mode 0: no sdo checks, 1: sdo_en must stay low, 2: read frame returning txw
    task automatic spi_xfer(input logic [63:0] bits, input int nbits, input int mode,
                            input logic [31:0] txw, input bit end_frame);
        logic [1:0] e;
        logic [1:0] got;
        @(negedge sys_clk);
        csb = 1'b0; sclk = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            if (mode != 0) begin
                if (mode == 2 && i >= 16 && i < 48) sdo_q.push_back({1'b1, txw[47 - i]});
                else sdo_q.push_back(2'b00);
            end
            sdi = bits[63 - i];
            #80;
            sclk = 1'b1;
            if (mode != 0) begin
                got = {sdo_en, sdo};
                e = sdo_q.pop_front();
                check($sformatf("sdo_en/sdo bit%0d", i), {30'd0, got}, {30'd0, e});
            end
            #80;
            sclk = 1'b0;
        end
        if (end_frame) begin
            #80;
            csb = 1'b1;
            #200;
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_st;
        logic [31:0] exp_rx;

        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_b = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Reset values
        apb_read_check(32'h0, 32'h0, "rst STATUS");
        apb_read_check(32'h4, 32'h0, "rst RX_DATA");
        apb_read_check(32'h8, 32'h0, "rst TX_DATA");
        apb_read_check(32'hC, 32'h0, "rst CTRL");

        // CTRL scratch, reserved bits read 0
        apb_write(32'hC, 32'hAAAA_AAFE);
        apb_read_check(32'hC, 32'hAAAA_AA00, "CTRL reserved");
        apb_write(32'hC, 32'hAAAA_AA00);
        apb_read_check(32'hC, 32'hAAAA_AA00, "CTRL scratch");

        // Write frame
        spi_xfer({8'h65, 8'h07, 32'h0102_0408, 16'h0}, 48, 1, 32'h0, 1'b1);
        apb_read_check(32'h0, 32'h0000_0702, "wr STATUS");
        apb_read_check(32'h4, 32'h0102_0408, "wr RX_DATA");
        apb_read_check(32'h0, 32'h0000_0700, "rx_valid cleared");

        // Bits past 48 are ignored, no frame error
        spi_xfer({8'h65, 8'h44, 32'hCAFE_F00D, 8'hFF, 8'h00}, 56, 0, 32'h0, 1'b1);
        apb_read_check(32'h0, 32'h0000_4402, "56b STATUS");
        apb_read_check(32'h4, 32'hCAFE_F00D, "56b RX_DATA");
        exp_st = 32'h0000_4400;
        exp_rx = 32'hCAFE_F00D;

        // Read frame; TX_DATA rewritten mid-frame must not disturb the shifted word
        apb_write(32'h8, 32'h1234_5678);
        fork
            spi_xfer({8'hE5, 8'h0F, 32'hFFFF_FFFF, 16'h0}, 48, 2, 32'h1234_5678, 1'b1);
            begin
                #4000;
                apb_write(32'h8, 32'hDEAD_BEEF);
            end
        join
        exp_st = 32'h0000_0F08;
        apb_read_check(32'h0, exp_st, "rd STATUS");
        apb_read_check(32'h4, exp_rx, "rd RX_DATA");
        apb_read_check(32'h8, 32'hDEAD_BEEF, "rd TX_DATA");

        // Foreign ID frame
        spi_xfer({8'h15, 8'h22, 32'hAABB_CCDD, 16'h0}, 48, 1, 32'h0, 1'b1);
`ifdef SPI_SLAVE_ID_CHECK_EN
        apb_read_check(32'h0, exp_st, "id STATUS");
        apb_read_check(32'h4, exp_rx, "id RX_DATA");
`else
        exp_rx = 32'hAABB_CCDD;
        apb_read_check(32'h0, 32'h0000_2202, "id STATUS");
        apb_read_check(32'h4, exp_rx, "id RX_DATA");
        exp_st = 32'h0000_2200;
`endif

        // Disabled: a read frame is ignored, sdo_en stays low
        apb_write(32'hC, 32'hAAAA_AA01);
        spi_xfer({8'hE5, 8'h33, 32'h1122_3344, 16'h0}, 48, 1, 32'h0, 1'b1);
        apb_read_check(32'h0, exp_st, "dis STATUS");
        apb_read_check(32'h4, exp_rx, "dis RX_DATA");
        apb_write(32'hC, 32'hAAAA_AA00);

        // Truncated frame
        spi_xfer({8'h65, 8'h55, 48'h9999_9999_9999}, 20, 1, 32'h0, 1'b1);
        apb_read_check(32'h4, exp_rx, "trunc RX_DATA");
        apb_read_check(32'h0, exp_st | 32'h4, "trunc frame_err");
        apb_read_check(32'h0, exp_st, "frame_err cleared");

        // Reset mid-frame aborts without frame_err
        spi_xfer({8'h65, 8'h66, 48'h5555_5555_5555}, 10, 0, 32'h0, 1'b0);
        @(negedge sys_clk);
        rst_b = 1'b0;
        repeat (4) @(negedge sys_clk);
        rst_b = 1'b1;
        csb = 1'b1;
        #200;
        apb_read_check(32'h0, 32'h0, "midrst STATUS");
        apb_read_check(32'h4, 32'h0, "midrst RX_DATA");
        apb_read_check(32'h8, 32'h0, "midrst TX_DATA");
        apb_read_check(32'hC, 32'h0, "midrst CTRL");
        check("midrst sdo_en/sdo", {30'd0, sdo_en, sdo}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
